// File: rtl/spi_master.sv
// spi_master: serialises a 10-bit command word onto SS_n/MOSI, one bit per clk,
// and shifts in the 8-bit MISO reply on rd-data frames.
module spi_master #(
   parameter int TURNAROUND = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [9:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);
   typedef enum logic [2:0] {IDLE, CMD, SHIFT, WAIT, RECV, GAP} state_t;
   localparam logic [3:0] TA_LAST  = 4'(TURNAROUND - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
   state_t     state, state_d;
   logic [3:0] cnt, cnt_d;
   logic [9:0] sr, sr_d;
   logic [7:0] rx, rx_d, rd_data_d;
   logic       busy_d, done_d, rd_valid_d, ss_n_d, mosi_d;
   always_comb begin
      state_d    = state;
      cnt_d      = cnt + 4'd1;
      sr_d       = sr;
      rx_d       = rx;
      rd_data_d  = rd_data;
      busy_d     = busy;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      ss_n_d     = SS_n;
      mosi_d     = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = CMD;
               sr_d    = cmd_data;
               busy_d  = 1'b1;
               ss_n_d  = 1'b0;
               mosi_d  = cmd_data[9];
            end
         end
         CMD: begin
            state_d = SHIFT;
            mosi_d  = sr[9];
         end
         SHIFT: begin
            if (cnt == 4'd9) begin
               state_d = sr[9:8] == 2'b11 ? WAIT : GAP;
               ss_n_d  = sr[9:8] != 2'b11;
               done_d  = sr[9:8] != 2'b11;
            end else begin
               mosi_d = sr[4'd8 - cnt];
            end
         end
         WAIT: state_d = cnt == TA_LAST ? RECV : WAIT;
         RECV: begin
            rx_d = {rx[6:0], MISO};
            if (cnt == 4'd7) begin
               state_d    = GAP;
               ss_n_d     = 1'b1;
               done_d     = 1'b1;
               rd_valid_d = 1'b1;
               rd_data_d  = rx_d;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state) cnt_d = '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         sr       <= '0;
         rx       <= '0;
         rd_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_valid <= 1'b0;
         SS_n     <= 1'b1;
         MOSI     <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         sr       <= sr_d;
         rx       <= rx_d;
         rd_data  <= rd_data_d;
         busy     <= busy_d;
         done     <= done_d;
         rd_valid <= rd_valid_d;
         SS_n     <= ss_n_d;
         MOSI     <= mosi_d;
      end
   end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master for the single-port-RAM SPI subsystem.
- Converts a parallel 10-bit command/data word into a serial frame on SS_n/MOSI, and collects the 8-bit read byte returned on MISO for read-data commands.
- Runs on the system clock and shifts one bit per clk with no separate SCLK. It is the counterpart of the SPI slave that feeds the RAM.

Parameters:
- TURNAROUND, 2: SS_n-low, idle-MOSI cycles between the last command bit and the first MISO sample on read-data frames; minimum 1.
- GAP_CYCLES, 1: SS_n-high cycles forced after every frame before the next start is accepted; minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a frame; accepted only when busy=0
- cmd_data  input  10  frame word; [9:8] = opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] = payload
- busy  output  1  frame in progress or gap pending
- done  output  1  one-cycle pulse at frame end
- rd_data  output  8  byte received on the last rd-data frame
- rd_valid  output  1  one-cycle pulse, rd_data updated
- SS_n  output  1  slave select, active low
- MOSI  output  1  serial data to slave
- MISO  input  1  serial data from slave

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge) values: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, state IDLE, counters 0.
- Reset mid-frame aborts immediately: SS_n high next cycle, no done, no rd_valid.
- FSM states: IDLE, CMD, SHIFT, WAIT, RECV, GAP.
- Acceptance:
  - In IDLE, start=1 at edge T0 latches cmd_data into an internal shift register and moves to CMD; busy=1 from cycle 1.
  - start while busy=1 is ignored and not queued.
- Cycle numbering (cycle n = the cycle after edge T0+n-1):
  - Cycle 1 (CMD): SS_n=0, MOSI=cmd[9]. This is the slave's command-check bit.
  - Cycles 2..11 (SHIFT): SS_n=0, MOSI=cmd[9],cmd[8],...,cmd[0], MSB first, one bit per cycle. cmd[9] therefore appears twice.
  - Opcode 00/01/10: cycle 12 enters GAP with SS_n=1, MOSI=0, done=1 for that single cycle.
  - Opcode 11, WAIT: cycles 12..11+TURNAROUND, SS_n=0, MOSI=0.
  - Opcode 11, RECV: 8 cycles, SS_n=0, MOSI=0. MISO is sampled at the end of each cycle and shifted in MSB first.
  - Opcode 11, end of RECV: next cycle enters GAP with SS_n=1, rd_data = assembled byte, rd_valid=1 and done=1 in that same cycle.
- GAP:
  - Lasts GAP_CYCLES cycles with SS_n=1 and busy=1.
  - Then returns to IDLE with busy=0.
  - A start presented on the first IDLE cycle is accepted.
- Counter:
  - One 4-bit bit counter, cleared on every state entry.
  - SHIFT exits on count 9, WAIT on TURNAROUND-1, RECV on 7, GAP on GAP_CYCLES-1.
- rd_data holds its value until the next rd-data frame completes and is unaffected by write or rd-addr frames.
- MISO is ignored outside RECV.
- Opcode and payload are not validated; any 10-bit value is sent verbatim.
- Frame length:
  - Write and rd-addr frames: SS_n low 11 cycles.
  - Rd-data frames: SS_n low 19+TURNAROUND cycles.
  - Start-to-start minimum spacing = SS_n-low cycles + GAP_CYCLES + 1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00 throughout.
- Write-address frame: start with cmd_data=10'b00_1010_0101 → SS_n low exactly 11 cycles; MOSI sequence 0,0,0,1,0,1,0,0,1,0,1; done pulses once on the first SS_n-high cycle; rd_valid stays 0.
- Read-data frame, TURNAROUND=2: cmd_data=10'b11_0000_0000, slave model drives MISO=1,0,1,1,0,0,1,0 in cycles 14..21 → rd_data=8'hB2; rd_valid and done high together for one cycle at cycle 22; SS_n low cycles 1..21.
- Back-to-back: start held high continuously with two different write words → second frame's SS_n falls exactly GAP_CYCLES+1 cycles after the first frame's SS_n rises; start pulses during busy do not create extra frames.
- Reset mid-frame: assert rst_n=0 in cycle 6 of a rd-data frame → SS_n=1 next cycle, no done, no rd_valid, rd_data cleared to 0. A new start after release produces a clean, complete frame.
- Loopback with the SPI slave + RAM: write-addr 0x10, write-data 0x5A, rd-addr 0x10, rd-data → rd_data=8'h5A, rd_valid one pulse.
